// File: rtl/ram_sx_be.sv
// rtl/ram_sx_be.sv - single-port RAM with lane write masks, read-during-write modes and zero-fill sequencer
module ram_sx_be #(
    parameter int CAddrLen   = 10,
    parameter int CDataLen   = 64,
    parameter int CByteLen   = 8,
    parameter int CRdMode    = 0,
    parameter int COutReg    = 0,
    parameter int CInitClear = 1,
    localparam int CLaneCnt  = CDataLen / CByteLen
) (
    input  logic                AClkH,
    input  logic                AResetHN,
    input  logic                AClkHEn,
    input  logic [CAddrLen-1:0] AAddr,
    input  logic [CDataLen-1:0] AMosi,
    input  logic                AWrEn,
    input  logic [CLaneCnt-1:0] AWrMask,
    input  logic                ARdEn,
    output logic [CDataLen-1:0] AMiso,
    output logic                AMisoVld,
    output logic                AReady
);

    if (CDataLen % CByteLen != 0) begin : g_bad_lane
        $error("ram_sx_be: CDataLen must be a multiple of CByteLen");
    end

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t              state_q;
    logic [CAddrLen:0]   cnt_q;
    logic [CAddrLen:0]   cnt_d;
    logic [CDataLen-1:0] mem_q [2**CAddrLen];
    logic [CDataLen-1:0] rdata_q;
    logic                vld1_q;

    logic                clearing;
    logic                ready;
    logic                rd_acc;
    logic [CAddrLen-1:0] wr_addr;
    logic [CDataLen-1:0] wr_data;
    logic [CLaneCnt-1:0] lane_we;

    assign ready    = (state_q == ST_READY);
    assign clearing = (state_q == ST_CLEAR);
    assign cnt_d    = cnt_q + 1'b1;
    assign wr_addr  = clearing ? cnt_q[CAddrLen-1:0] : AAddr;
    assign wr_data  = clearing ? '0 : AMosi;
    // No-change mode refuses a read that collides with a write.
    assign rd_acc   = ready && ARdEn && !((CRdMode == 1) && AWrEn);

    always_comb begin
        lane_we = '0;
        for (int i = 0; i < CLaneCnt; i++) begin
            lane_we[i] = AResetHN && AClkHEn && (clearing || (ready && AWrEn && AWrMask[i]));
        end
    end

    // Terminal count is taken from the extra MSB so address 0 is never mistaken for the end.
    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            cnt_q   <= '0;
            state_q <= (CInitClear != 0) ? ST_CLEAR : ST_READY;
        end else if (AClkHEn && clearing) begin
            cnt_q <= cnt_d;
            if (cnt_d[CAddrLen]) begin
                state_q <= ST_READY;
            end
        end
    end

    always_ff @(posedge AClkH) begin
        for (int i = 0; i < CLaneCnt; i++) begin
            if (lane_we[i]) begin
                mem_q[wr_addr][i*CByteLen +: CByteLen] <= wr_data[i*CByteLen +: CByteLen];
            end
            if (AResetHN && AClkHEn && rd_acc) begin
                rdata_q[i*CByteLen +: CByteLen] <= ((CRdMode == 2) && AWrEn && AWrMask[i])
                    ? AMosi[i*CByteLen +: CByteLen]
                    : mem_q[AAddr][i*CByteLen +: CByteLen];
            end
        end
    end

    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            vld1_q <= 1'b0;
        end else if (AClkHEn) begin
            vld1_q <= rd_acc;
        end
    end

    if (COutReg != 0) begin : g_out_reg
        logic [CDataLen-1:0] out_q;
        logic                vld2_q;

        always_ff @(posedge AClkH) begin
            if (!AResetHN) begin
                vld2_q <= 1'b0;
            end else if (AClkHEn) begin
                vld2_q <= vld1_q;
                if (vld1_q) begin
                    out_q <= rdata_q;
                end
            end
        end

        assign AMisoVld = vld2_q;
        assign AMiso    = vld2_q ? out_q : '0;
    end else begin : g_no_out_reg
        assign AMisoVld = vld1_q;
        assign AMiso    = vld1_q ? rdata_q : '0;
    end

    assign AReady = ready;

endmodule
